regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the CPU core: configurable data width, depth and read-port count, two write ports with defined priority, same-cycle write-to-read bypass, and a sequential clear engine after reset. An optional scoreboard tracks pending writes so the issue stage can detect RAW hazards. It sits between decode (read ports, scoreboard set) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Optional feature macro: REGFILE_SCOREBOARD_EN (pending-write scoreboard).
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 3;

    // CLEAR sweeps the array to zero after reset; READY is normal operation.
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_if import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    logic                       init_done;
    logic                       we0;
    logic [ADDR_W-1:0]          waddr0;
    logic [DATA_W-1:0]          wdata0;
    logic                       we1;
    logic [ADDR_W-1:0]          waddr1;
    logic [DATA_W-1:0]          wdata1;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic                       sb_set;
    logic [ADDR_W-1:0]          sb_set_addr;
    logic [NUM_RD-1:0]          rbusy;

    modport master (
        input  init_done, rdata, rbusy,
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set, sb_set_addr
    );

    modport slave (
        output init_done, rdata, rbusy,
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set, sb_set_addr
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one busy bit per entry, set by issue, cleared by
// writeback, with a same-cycle clear bypass on every read port.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ready,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     we0,      // already qualified with ready
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic                     we1,      // already qualified with ready
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        rbusy
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy;
    logic             set_ok;

    // Entry 0 is hard-wired when ZERO_REG is on, so it can never go busy.
    assign set_ok = ready && sb_set && !(ZERO_EN && (sb_set_addr == '0));

    // Clears first, set last so a same-address set overrides the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (we0)    busy[waddr0]      <= 1'b0;
            if (we1)    busy[waddr1]      <= 1'b0;
            if (set_ok) busy[sb_set_addr] <= 1'b1;
        end
    end

    // Per-port busy lookup; a write landing this cycle hides the stale bit.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra    = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra       = raddr[i*ADDR_W +: ADDR_W];
            rbusy[i] = ready && busy[ra]
                       && !(we1 && (waddr1 == ra))
                       && !(we0 && (waddr0 == ra))
                       && !(ZERO_EN && (ra == '0));
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with same-cycle
// write bypass, two write ports (port 1 wins on collision), zero-sweep after
// reset. Define REGFILE_SCOREBOARD_EN to build the RAW-hazard scoreboard;
// otherwise rbusy is tied low and sb_set/sb_set_addr are ignored.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    rf_state_e                       state;
    logic [ADDR_W-1:0]               clr_idx;
    logic                            ready;
    logic                            we0_act;
    logic                            we1_act;
    logic                            wr0;
    logic                            wr1;
    logic [DATA_W-1:0]               mem [DEPTH];
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_word;

    assign ready         = (state == RF_READY);
    assign bus.init_done = ready;

    // Writes only exist once the sweep is done.
    assign we0_act = ready && bus.we0;
    assign we1_act = ready && bus.we1;
    assign wr0     = we0_act && !(ZERO_EN && (bus.waddr0 == '0));
    assign wr1     = we1_act && !(ZERO_EN && (bus.waddr1 == '0));

    // Clear sequencer: one entry per cycle, READY after the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else if (state == RF_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (&clr_idx) state <= RF_READY;
        end
    end

    // Storage array (no reset): sweep writes zero, else port 1 lands last.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_idx] <= '0;
        end else begin
            if (wr0) mem[bus.waddr0] <= bus.wdata0;
            if (wr1) mem[bus.waddr1] <= bus.wdata1;
        end
    end

    // Read mux per port: zero reg, younger writer, older writer, array.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.raddr[i*ADDR_W +: ADDR_W];
            if (!ready || (ZERO_EN && (ra == '0)))
                rd_word[i] = '0;
            else if (bus.we1 && (bus.waddr1 == ra))
                rd_word[i] = bus.wdata1;
            else if (bus.we0 && (bus.waddr0 == ra))
                rd_word[i] = bus.wdata0;
            else
                rd_word[i] = mem[ra];
        end
    end

    assign bus.rdata = rd_word;

`ifdef REGFILE_SCOREBOARD_EN
    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .sb_set      (bus.sb_set),
        .sb_set_addr (bus.sb_set_addr),
        .we0         (we0_act),
        .waddr0      (bus.waddr0),
        .we1         (we1_act),
        .waddr1      (bus.waddr1),
        .raddr       (bus.raddr),
        .rbusy       (bus.rbusy)
    );
`else
    logic sb_unused;
    assign sb_unused = ^{bus.sb_set, bus.sb_set_addr};
    assign bus.rbusy = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sweep, bypass, write priority, zero
// register, scoreboard (when built) and reset during the sweep.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int p);
        return bus.rdata[p*DW +: DW];
    endfunction

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.raddr = {a2, a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until init_done, bounded; checks read-as-zero mid-sweep.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (!bus.init_done && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 5) chk("clear_rdata", rd(0), 32'h0);
        end
    endtask

    initial begin
        bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'hDEAD;
        bus.we1 = 1'b0; bus.waddr1 = '0;   bus.wdata1 = '0;
        bus.sb_set = 1'b0; bus.sb_set_addr = '0;
        set_raddr(5'd9, 5'd9, 5'd9);

        // Reset state: no bypass, no busy, not initialised
        #2;
        chk("rst_init_done", {31'b0, bus.init_done}, 32'h0);
        chk("rst_rdata0", rd(0), 32'h0);
        chk("rst_rdata2", rd(2), 32'h0);
        chk("rst_rbusy", {29'b0, bus.rbusy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Sweep takes DEPTH edges; the write held on port 0 must be dropped
        wait_init(n);
        bus.we0 = 1'b0;
        chk("init_edges", n, DEPTH);
        #1;
        chk("clear_write_dropped", rd(0), 32'h0);

        // Every entry reads zero after the sweep
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr(AW'(a), AW'((a + 1) % DEPTH), AW'((a + 2) % DEPTH));
            #1;
            for (int p = 0; p < NR; p++) chk("sweep_zero", rd(p), 32'h0);
        end

        // Port 0 write with same-cycle read bypass, then from the array
        tick();
        bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'h1234;
        set_raddr(5'd5, 5'd5, 5'd6);
        #1;
        chk("wr0_bypass_p0", rd(0), 32'h1234);
        chk("wr0_bypass_p1", rd(1), 32'h1234);
        chk("wr0_other_p2", rd(2), 32'h0);
        tick();
        bus.we0 = 1'b0;
        #1;
        chk("wr0_stored", rd(0), 32'h1234);

        // Both ports hit address 7: port 1 wins in bypass and in the array
        bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'hAAAA;
        bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h5555;
        set_raddr(5'd7, 5'd7, 5'd5);
        #1;
        chk("coll_bypass", rd(0), 32'h5555);
        chk("coll_other", rd(2), 32'h1234);
        tick();
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        #1;
        chk("coll_stored", rd(1), 32'h5555);

        // Distinct addresses on the two ports, third port from the array
        bus.we0 = 1'b1; bus.waddr0 = 5'd8; bus.wdata0 = 32'h11;
        bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h22;
        set_raddr(5'd8, 5'd9, 5'd7);
        #1;
        chk("dual_p0", rd(0), 32'h11);
        chk("dual_p1", rd(1), 32'h22);
        chk("dual_p2", rd(2), 32'h5555);
        tick();
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        #1;
        chk("dual_st0", rd(0), 32'h11);
        chk("dual_st1", rd(1), 32'h22);

        // Address 0 is hard zero for bypass and storage
        bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF;
        bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFF;
        set_raddr(5'd0, 5'd0, 5'd8);
        #1;
        chk("zero_bypass", rd(0), 32'h0);
        chk("zero_other", rd(2), 32'h11);
        tick();
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        #1;
        chk("zero_stored", rd(1), 32'h0);

        // Scoreboard set/clear behaviour
        set_raddr(5'd3, 5'd3, 5'd3);
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd3;
        #1;
        chk("sb_set_not_yet", {29'b0, bus.rbusy}, 32'h0);
        tick();
        bus.sb_set = 1'b0;
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        chk("sb_set_visible", {29'b0, bus.rbusy}, 32'h7);
`else
        chk("sb_off_tied", {29'b0, bus.rbusy}, 32'h0);
`endif
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h33;
        #1;
        chk("sb_clr_bypass", {29'b0, bus.rbusy}, 32'h0);
        tick();
        bus.we0 = 1'b0;
        #1;
        chk("sb_cleared", {29'b0, bus.rbusy}, 32'h0);
        chk("sb_data", rd(0), 32'h33);
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd3;
        bus.we1 = 1'b1; bus.waddr1 = 5'd3; bus.wdata1 = 32'h44;
        #1;
        chk("sb_setclr_bypass", {29'b0, bus.rbusy}, 32'h0);
        tick();
        bus.sb_set = 1'b0; bus.we1 = 1'b0;
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        chk("sb_set_wins", {29'b0, bus.rbusy}, 32'h7);
`else
        chk("sb_off_tied2", {29'b0, bus.rbusy}, 32'h0);
`endif
        set_raddr(5'd0, 5'd3, 5'd4);
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd0;
        tick();
        bus.sb_set = 1'b0;
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        chk("sb_zero_never", {29'b0, bus.rbusy}, 32'h2);
`else
        chk("sb_zero_never", {29'b0, bus.rbusy}, 32'h0);
`endif

        // Reset mid-sweep restarts the count; busy and array come back clear
        set_raddr(5'd5, 5'd7, 5'd3);
        rst_n = 1'b0;
        #1;
        chk("rst2_init_done", {31'b0, bus.init_done}, 32'h0);
        chk("rst2_rdata", rd(0), 32'h0);
        chk("rst2_rbusy", {29'b0, bus.rbusy}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("mid_clear_busy", {31'b0, bus.init_done}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_init_done", {31'b0, bus.init_done}, 32'h0);
        tick();
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_edges", n, DEPTH);
        #1;
        chk("reinit_p0", rd(0), 32'h0);
        chk("reinit_p1", rd(1), 32'h0);
        chk("reinit_p2", rd(2), 32'h0);
        chk("reinit_rbusy", {29'b0, bus.rbusy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
